// File: rtl/pipe_register_pkg.sv
`default_nettype none
// ============================================================================
// pipe_register_pkg : shared defaults and occupancy width helper
// Revision: 1.0
// ============================================================================
package pipe_register_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_DEPTH = 2;

  function automatic int OCC_W(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_register_stage.sv
`default_nettype none
// ============================================================================
// pipe_register_stage : one elastic register slot; empty slots always accept
// Revision: 1.0
// ============================================================================
module pipe_register_stage
  import pipe_register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             vld,
  output logic [WIDTH-1:0] dat,
  output logic             rdy
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  assign rdy = !vld_q || dn_ready;
  assign vld = vld_q;
  assign dat = dat_q;

  // Data only moves on a valid load so idle stages do not toggle.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (rdy) begin
      vld_d = up_valid;
      if (up_valid) begin
        dat_d = up_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_register_chain.sv
`default_nettype none
// ============================================================================
// pipe_register_chain : DEPTH-stage elastic register chain with flush.
// Optional occupancy output enabled by defining PIPE_REG_COUNT_EN.
// Revision: 1.0
// ============================================================================
module pipe_register_chain
  import pipe_register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data
`ifdef PIPE_REG_COUNT_EN
  ,
  output logic [OCC_W(DEPTH)-1:0] occupancy
`endif
);

  if (DEPTH < 1) begin : g_depth_check
    $error("pipe_register_chain: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0] stg_vld;
  logic [DEPTH-1:0] stg_rdy;
  logic [WIDTH-1:0] stg_dat [DEPTH];
  logic             in_fire;

  assign in_ready  = stg_rdy[0] && !flush && !reset;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = stg_vld[DEPTH-1];
  assign out_data  = stg_dat[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic             dn_r;

    if (i == 0) begin : g_src_in
      assign up_v = in_fire;
      assign up_d = in_data;
    end else begin : g_src_prev
      assign up_v = stg_vld[i-1];
      assign up_d = stg_dat[i-1];
    end

    if (i == DEPTH - 1) begin : g_dn_out
      assign dn_r = out_ready;
    end else begin : g_dn_next
      assign dn_r = stg_rdy[i+1];
    end

    pipe_register_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .up_valid (up_v),
      .up_data  (up_d),
      .dn_ready (dn_r),
      .vld      (stg_vld[i]),
      .dat      (stg_dat[i]),
      .rdy      (stg_rdy[i])
    );
  end

`ifdef PIPE_REG_COUNT_EN
  localparam logic [OCC_W(DEPTH)-1:0] OCC_ONE = 1;

  logic [OCC_W(DEPTH)-1:0] occ_q, occ_d;
  logic                    out_fire;

  assign out_fire  = out_valid && out_ready;
  assign occupancy = occ_q;

  // Simultaneous in/out transfer leaves the count unchanged.
  always_comb begin
    occ_d = occ_q;
    case ({in_fire, out_fire})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end
`endif

endmodule
`default_nettype wire
